signed_or_unsigned_div: RTL and testbench



---
 rtl/signed_or_unsigned_div_pkg.sv | 22 ++
 rtl/signed_or_unsigned_div_restoring_step.sv | 24 ++
 rtl/signed_or_unsigned_div.sv | 135 +++++++++++++
 tb/tb_signed_or_unsigned_div.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/signed_or_unsigned_div_pkg.sv
// Shared types and helpers for the iterative signed/unsigned divider.
// The state encoding and the two's-complement magnitude helper live here.
package signed_or_unsigned_div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    // Widest operand the magnitude helper handles; callers size-cast in and out.
    localparam int MAX_W = 64;

    // Magnitude of a two's-complement value. The caller passes the operand
    // zero-extended and says whether it is negative. Taking the low n bits of
    // the result gives |x|, and -2^(n-1) comes back as unsigned 2^(n-1).
    function automatic logic [MAX_W-1:0] magnitude(input logic [MAX_W-1:0] v,
                                                   input logic             neg);
        return neg ? (~v + MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/signed_or_unsigned_div_restoring_step.sv
// One restoring-division step. It shifts the next dividend bit into the partial
// remainder and subtracts the divisor when that leaves no borrow.
module div_restoring_step #(
    parameter int n = 8
) (
    input  logic [n:0]   pr,
    input  logic         dbit,
    input  logic [n-1:0] divisor,
    output logic [n:0]   pr_next,
    output logic         qbit
);

    logic [n+1:0] trial;
    logic [n+1:0] dext;

    always_comb begin
        trial   = {pr, dbit};
        dext    = (n+2)'(divisor);
        qbit    = (trial >= dext);
        // The kept remainder is always below the divisor, so n+1 bits hold it.
        pr_next = (n+1)'(qbit ? (trial - dext) : trial);
    end

endmodule

// File: rtl/signed_or_unsigned_div.sv
// Iterative divider producing one quotient bit per clock, signed or unsigned per request.
// Optional macro SIGNED_OR_UNSIGNED_DIV_EARLY_OUT_EN skips the iterations for b==0 or |a|<|b|.
module signed_or_unsigned_div
    import signed_or_unsigned_div_pkg::*;
#(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic         sign,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] quo,
    output logic [n-1:0] rem
);

    localparam int CW = $clog2(n);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [n-1:0]  a_raw;
    logic [n-1:0]  b_mag;
    logic [n-1:0]  dq;        // dividend magnitude shifts out the top, quotient bits shift in the bottom
    logic [n:0]    pr;
    logic          neg_q;
    logic          neg_r;
    logic          div_zero;
    logic          skip;

    logic [n:0]    pr_next;
    logic          qbit;
    logic [n-1:0]  a_mag_in;
    logic [n-1:0]  b_mag_in;
    logic [n-1:0]  q_mag;
    logic [n-1:0]  r_mag;
    logic [n-1:0]  quo_fix;
    logic [n-1:0]  rem_fix;
    logic          early_hit;

    div_restoring_step #(.n(n)) u_step (
        .pr      (pr),
        .dbit    (dq[n-1]),
        .divisor (b_mag),
        .pr_next (pr_next),
        .qbit    (qbit)
    );

    // NOTE: every always_comb output gets a value on every path before any
    // conditional override, so no latch can be inferred.
    always_comb begin
        a_mag_in = n'(magnitude(MAX_W'(a), sign & a[n-1]));
        b_mag_in = n'(magnitude(MAX_W'(b), sign & b[n-1]));
        q_mag    = {dq[n-2:0], qbit};
        r_mag    = pr_next[n-1:0];
        quo_fix  = neg_q ? -q_mag : q_mag;
        rem_fix  = neg_r ? -r_mag : r_mag;
        if (div_zero) begin
            quo_fix = '1;
            rem_fix = a_raw;
        end else if (skip) begin
            quo_fix = '0;
            rem_fix = a_raw;
        end
    end

`ifdef SIGNED_OR_UNSIGNED_DIV_EARLY_OUT_EN
    assign early_hit = (b == '0) || (a_mag_in < b_mag_in);
`else
    assign early_hit = 1'b0;
`endif

    // NOTE: all state uses non-blocking assignments, so every register in this
    // block sees the values from before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            a_raw     <= '0;
            b_mag     <= '0;
            dq        <= '0;
            pr        <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div_zero  <= 1'b0;
            skip      <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            quo       <= '0;
            rem       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_raw    <= a;
                        b_mag    <= b_mag_in;
                        dq       <= a_mag_in;
                        pr       <= '0;
                        neg_q    <= sign & (a[n-1] ^ b[n-1]);
                        neg_r    <= sign & a[n-1];
                        div_zero <= (b == '0);
                        skip     <= early_hit;
                        cnt      <= CW'(n - 1);
                        in_ready <= 1'b0;
                        state    <= CALC;
                    end
                end
                CALC: begin
                    pr  <= pr_next;
                    dq  <= {dq[n-2:0], qbit};
                    cnt <= cnt - CW'(1);
                    // The last step's result is used combinationally, so the fix-up lands on the same edge.
                    if (skip || cnt == '0) begin
                        quo       <= quo_fix;
                        rem       <= rem_fix;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_signed_or_unsigned_div.sv
// Scoreboard bench for signed_or_unsigned_div at n=4: directed corner cases,
// an exhaustive sweep of both modes and random requests, all with random out_ready stalls.
module tb_signed_or_unsigned_div;

    localparam int N = 4;

    typedef struct {
        logic [N-1:0] quo;
        logic [N-1:0] rem;
        int           lat;
        int           acc_cyc;
        logic [N-1:0] a;
        logic [N-1:0] b;
        bit           s;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         sign;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quo;
    logic [N-1:0] rem;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    signed_or_unsigned_div #(.n(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sign      (sign),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quo       (quo),
        .rem       (rem)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name, input string detail);
        total++;
        bad++;
        $display("FAIL %s: %s (t=%0t)", name, detail, $time);
    endtask

    // Reference: plain integer division; SV int '/' and '%' truncate toward zero
    // and give the remainder the dividend's sign.
    function automatic exp_t model(input logic [N-1:0] ua, input logic [N-1:0] ub, input bit s);
        exp_t e;
        int sa, sbv, ma, mb, q, r;
        sa  = s ? int'($signed(ua)) : int'(ua);
        sbv = s ? int'($signed(ub)) : int'(ub);
        ma  = (sa < 0) ? -sa : sa;
        mb  = (sbv < 0) ? -sbv : sbv;
        e.a = ua;
        e.b = ub;
        e.s = s;
        e.acc_cyc = 0;
        if (sbv == 0) begin
            e.quo = '1;
            e.rem = ua;
        end else begin
            q = sa / sbv;
            r = sa % sbv;
            e.quo = q[N-1:0];
            e.rem = r[N-1:0];
        end
        e.lat = N;
`ifdef SIGNED_OR_UNSIGNED_DIV_EARLY_OUT_EN
        if (sbv == 0 || ma < mb) e.lat = 1;
`else
        if (ma < 0 || mb < 0) e.lat = -1;
`endif
        return e;
    endfunction

    task automatic issue(input logic [N-1:0] ia, input logic [N-1:0] ib, input bit s);
        exp_t e;
        int waited;
        waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        a        = ia;
        b        = ib;
        sign     = s;
        while (in_ready !== 1'b1) begin
            @(negedge clk);
            waited++;
            if (waited > 200) begin
                flag("accept_timeout", "in_ready never rose within 200 cycles");
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        #1;
        e = model(ia, ib, s);
        e.acc_cyc = cyc;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        int t;
        t = 0;
        @(negedge clk);
        in_valid = 1'b0;
        while ((sb_q.size() != 0 || out_valid === 1'b1) && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) flag("drain_timeout", "results still pending after 500 cycles");
    endtask

    // Monitor: pops the scoreboard on each new result and drives out_ready stalls.
    initial begin
        exp_t         e;
        bit           have;
        bit           prev_hs;
        int           hold;
        int           n_out;
        logic [N-1:0] held_q;
        logic [N-1:0] held_r;
        have    = 0;
        prev_hs = 0;
        hold    = 0;
        n_out   = 0;
        out_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_hs) begin
                check("in_ready_after_handshake", 32'(in_ready), 32'd1);
                check("out_valid_after_handshake", 32'(out_valid), 32'd0);
                prev_hs = 0;
            end
            if (out_valid === 1'b1) begin
                if (!have) begin
                    have   = 1;
                    held_q = quo;
                    held_r = rem;
                    if (sb_q.size() == 0) begin
                        flag("unexpected_output", $sformatf("quo=%0h rem=%0h with nothing pending", quo, rem));
                    end else begin
                        e = sb_q.pop_front();
                        check($sformatf("quo a=%0h b=%0h s=%0d", e.a, e.b, e.s), 32'(quo), 32'(e.quo));
                        check($sformatf("rem a=%0h b=%0h s=%0d", e.a, e.b, e.s), 32'(rem), 32'(e.rem));
                        check($sformatf("latency a=%0h b=%0h s=%0d", e.a, e.b, e.s), 32'(cyc - e.acc_cyc), 32'(e.lat));
                    end
                    hold = (n_out == 0) ? 3 : int'($urandom_range(0, 2));
                    n_out++;
                end else begin
                    check("quo_stable_while_stalled", 32'(quo), 32'(held_q));
                    check("rem_stable_while_stalled", 32'(rem), 32'(held_r));
                end
                check("in_ready_low_while_valid", 32'(in_ready), 32'd0);
                if (hold > 0) begin
                    out_ready = 1'b0;
                    hold--;
                end else begin
                    out_ready = 1'b1;
                    have      = 0;
                    prev_hs   = 1;
                end
            end else begin
                out_ready = 1'(($urandom_range(0, 1)));
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        sign     = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_quo", 32'(quo), 32'd0);
        check("reset_rem", 32'(rem), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // Directed corners; the first result is held off for three cycles by the monitor.
        issue(4'd13, 4'd3, 1'b0);
        issue(4'b1001, 4'b0010, 1'b1);
        issue(4'd7, 4'b1110, 1'b1);
        issue(4'b1000, 4'b1111, 1'b1);
        issue(4'd9, 4'd0, 1'b0);
        issue(4'b1001, 4'd0, 1'b1);
        issue(4'd2, 4'd5, 1'b0);
        drain();

        // Abort during the second CALC cycle.
        @(negedge clk);
        a = 4'd13; b = 4'd3; sign = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_quo", 32'(quo), 32'd0);
        check("abort_rem", 32'(rem), 32'd0);
        rst = 1'b0;
        issue(4'd11, 4'd4, 1'b0);
        drain();

        // Exhaustive sweep, both modes, with occasional idle gaps.
        for (int s = 0; s < 2; s++) begin
            for (int ia = 0; ia < 16; ia++) begin
                for (int ib = 0; ib < 16; ib++) begin
                    issue(4'(ia), 4'(ib), 1'(s));
                    if ($urandom_range(0, 3) == 0) begin
                        @(negedge clk);
                        in_valid = 1'b0;
                    end
                end
            end
        end

        // Random requests.
        for (int i = 0; i < 100; i++) begin
            issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
